// File: rtl/fp8_stream_unpack_if.sv
// Handshake bundle for the FP8->FP32 widener: packed-word input stream and FP32 element output stream.
// The slave modport is the widener's view; master is the upstream/downstream environment's view.
interface fp8_stream_unpack_if #(
  parameter int LANES = 4
) ();
  localparam int NW = $clog2(LANES + 1);

  logic [8*LANES-1:0] word_i;
  logic [NW-1:0]      word_nlanes_i;
  logic               word_last_i;
  logic               word_valid_i;
  logic               word_ready_o;
  logic [31:0]        f32_o;
  logic               f32_valid_o;
  logic               f32_ready_i;
  logic               f32_last_o;
  logic               nan_o;
  logic [31:0]        elem_cnt_o;

  modport slave (
    input  word_i, word_nlanes_i, word_last_i, word_valid_i, f32_ready_i,
    output word_ready_o, f32_o, f32_valid_o, f32_last_o, nan_o, elem_cnt_o
  );

  modport master (
    output word_i, word_nlanes_i, word_last_i, word_valid_i, f32_ready_i,
    input  word_ready_o, f32_o, f32_valid_o, f32_last_o, nan_o, elem_cnt_o
  );
endinterface

// File: rtl/fp8_stream_unpack.sv
// Streaming FP8->FP32 widener: serializes packed FP8 lanes of a word into one exact FP32 element per handshake.
//  state | meaning
//  IDLE  | no word held, ready for a new word, output invalid
//  EMIT  | word held, f32_o presents lane lane_idx until accepted
module fp8_stream_unpack #(
  parameter int E     = 5,
  parameter int M     = 2,
  parameter int LANES = 4
) (
  input logic                clk,
  input logic                rst,
  fp8_stream_unpack_if.slave bus
);
  localparam int NW   = $clog2(LANES + 1);
  localparam int B8   = 2**(E-1) - 1;
  localparam int EMAX = 2**E - 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state;
  logic [8*LANES-1:0] word_q;
  logic [NW-1:0]      nlanes_q;
  logic [NW-1:0]      lane_idx;
  logic               last_q;
  logic [31:0]        f32_q;
  logic               valid_q;
  logic               last_out_q;
  logic               nan_q;
  logic [31:0]        cnt_q;

  // Returns {nan, fp32}. Every FP8 value is exactly representable in FP32.
  function automatic logic [32:0] conv(input logic [7:0] b);
    logic          s;
    logic [E-1:0]  e;
    logic [M-1:0]  m;
    logic [7:0]    ex;
    logic [22:0]   mt;
    logic          nan;
    int            p;
    s   = b[7];
    e   = b[E+M-1:M];
    m   = b[M-1:0];
    ex  = 8'd0;
    mt  = 23'd0;
    nan = 1'b0;
    p   = 0;
    if (e == '0) begin
      if (m != '0) begin
        for (int i = 0; i < M; i++)
          if (m[i]) p = i + 1;
        ex = 8'(127 + p - B8 - M);
        mt = {m, (23-M)'(0)} << (M - p + 1);
      end
    end else if (e == E'(EMAX)) begin
      ex = 8'hFF;
      if (m != '0) begin
        mt  = {m, (23-M)'(0)} | 23'h400000;
        nan = 1'b1;
      end
    end else begin
      ex = 8'(int'(e) - B8 + 127);
      mt = {m, (23-M)'(0)};
    end
    return {nan, s, ex, mt};
  endfunction

  function automatic logic [7:0] lane_sel(input logic [8*LANES-1:0] w, input logic [NW-1:0] idx);
    logic [7:0] r;
    r = 8'd0;
    for (int k = 0; k < LANES; k++)
      if (idx == NW'(k)) r = w[8*k +: 8];
    return r;
  endfunction

  logic [NW-1:0] nlanes_in;
  logic [NW-1:0] next_idx;
  logic          final_lane;
  logic [32:0]   conv_in;
  logic [32:0]   conv_next;

  // Zero (and any out-of-range count) means a full word.
  assign nlanes_in  = (bus.word_nlanes_i == '0 || bus.word_nlanes_i > NW'(LANES))
                      ? NW'(LANES) : bus.word_nlanes_i;
  assign next_idx   = lane_idx + NW'(1);
  assign final_lane = (lane_idx == nlanes_q - NW'(1));
  assign conv_in    = conv(bus.word_i[7:0]);
  assign conv_next  = conv(lane_sel(word_q, next_idx));

  // Combinational from f32_ready_i so a new word can follow the final lane without a bubble.
  assign bus.word_ready_o = (state == IDLE) || (final_lane && bus.f32_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_q     <= '0;
      nlanes_q   <= '0;
      lane_idx   <= '0;
      last_q     <= 1'b0;
      f32_q      <= 32'd0;
      valid_q    <= 1'b0;
      last_out_q <= 1'b0;
      nan_q      <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.word_valid_i) begin
            word_q     <= bus.word_i;
            nlanes_q   <= nlanes_in;
            last_q     <= bus.word_last_i;
            lane_idx   <= '0;
            f32_q      <= conv_in[31:0];
            nan_q      <= conv_in[32];
            last_out_q <= bus.word_last_i && (nlanes_in == NW'(1));
            valid_q    <= 1'b1;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (bus.f32_ready_i) begin
            cnt_q <= cnt_q + 32'd1;
            if (!final_lane) begin
              lane_idx   <= next_idx;
              f32_q      <= conv_next[31:0];
              nan_q      <= conv_next[32];
              last_out_q <= last_q && (next_idx == nlanes_q - NW'(1));
            end else if (bus.word_valid_i) begin
              word_q     <= bus.word_i;
              nlanes_q   <= nlanes_in;
              last_q     <= bus.word_last_i;
              lane_idx   <= '0;
              f32_q      <= conv_in[31:0];
              nan_q      <= conv_in[32];
              last_out_q <= bus.word_last_i && (nlanes_in == NW'(1));
            end else begin
              valid_q    <= 1'b0;
              last_out_q <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.f32_o       = f32_q;
  assign bus.f32_valid_o = valid_q;
  assign bus.f32_last_o  = last_out_q;
  assign bus.nan_o       = nan_q;
  assign bus.elem_cnt_o  = cnt_q;
endmodule

// File: tb/tb_fp8_stream_unpack.sv
// Directed scoreboard bench for fp8_stream_unpack: expected elements queued on stimulus, checked on output transfer.
module tb_fp8_stream_unpack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp8_stream_unpack_if #(.LANES(4)) bus ();

  fp8_stream_unpack #(.E(5), .M(2), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [31:0] f32;
    logic        last;
    logic        nan;
  } exp_t;

  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   cyc    = 0;
  int   total  = 0;
  int   fails  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] f, input logic l, input logic n);
    exp_q.push_back('{f32: f, last: l, nan: n});
  endtask

  always @(negedge clk) begin
    if (!rst && bus.f32_valid_o && bus.f32_ready_i) begin
      exp_t e;
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("f32", bus.f32_o, e.f32);
        chk("last", {31'd0, bus.f32_last_o}, {31'd0, e.last});
        chk("nan", {31'd0, bus.nan_o}, {31'd0, e.nan});
      end
    end
  end

  task automatic drive_word(input logic [31:0] w, input logic [2:0] nl, input logic l);
    bit acc;
    int n;
    bus.word_i        = w;
    bus.word_nlanes_i = nl;
    bus.word_last_i   = l;
    bus.word_valid_i  = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.word_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    chk("word_accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.word_i        = '0;
    bus.word_nlanes_i = '0;
    bus.word_last_i   = 1'b0;
    bus.word_valid_i  = 1'b0;
    bus.f32_ready_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_f32", bus.f32_o, 32'd0);
    chk("rst_valid", {31'd0, bus.f32_valid_o}, 32'd0);
    chk("rst_last", {31'd0, bus.f32_last_o}, 32'd0);
    chk("rst_nan", {31'd0, bus.nan_o}, 32'd0);
    chk("rst_cnt", bus.elem_cnt_o, 32'd0);
    chk("rst_word_ready", {31'd0, bus.word_ready_o}, 32'd1);
    @(posedge clk);
    #1;

    // Basic word with signed-zero-free mix: one, two subnormals, infinity.
    push_exp(32'h3F800000, 1'b0, 1'b0);
    push_exp(32'h37800000, 1'b0, 1'b0);
    push_exp(32'h38400000, 1'b0, 1'b0);
    push_exp(32'h7F800000, 1'b1, 1'b0);
    xfer_cyc.delete();
    drive_word(32'h7C03013C, 3'd4, 1'b1);
    bus.word_valid_i = 1'b0;
    wait_drain();
    chk("cnt_after_w1", bus.elem_cnt_o, 32'd4);
    chk("w1_consecutive", (xfer_cyc.size() == 4) ? xfer_cyc[3] - xfer_cyc[0] : -1, 32'd3);
    chk("idle_valid", {31'd0, bus.f32_valid_o}, 32'd0);

    // Max normal, negative zero, -inf, NaN; stall after lane 0.
    bus.f32_ready_i = 1'b0;
    push_exp(32'h47600000, 1'b0, 1'b0);
    push_exp(32'h80000000, 1'b0, 1'b0);
    push_exp(32'hFF800000, 1'b0, 1'b0);
    push_exp(32'h7FE00000, 1'b0, 1'b1);
    drive_word(32'h7DFC807B, 3'd4, 1'b0);
    bus.word_valid_i = 1'b0;
    @(posedge clk);
    #1;
    bus.f32_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.f32_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_f32", bus.f32_o, 32'h80000000);
      chk("stall_valid", {31'd0, bus.f32_valid_o}, 32'd1);
      chk("stall_word_ready", {31'd0, bus.word_ready_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.f32_ready_i = 1'b1;
    wait_drain();
    chk("cnt_after_stall", bus.elem_cnt_o, 32'd8);

    // Single-lane word carrying a quieted NaN.
    push_exp(32'h7FC00000, 1'b1, 1'b1);
    drive_word(32'h0000007E, 3'd1, 1'b1);
    bus.word_valid_i = 1'b0;
    wait_drain();
    chk("cnt_after_nan", bus.elem_cnt_o, 32'd9);

    // Partial word: upper lanes must be ignored.
    push_exp(32'h3F800000, 1'b0, 1'b0);
    push_exp(32'h3F800000, 1'b1, 1'b0);
    drive_word(32'hAAAA3C3C, 3'd2, 1'b1);
    bus.word_valid_i = 1'b0;
    wait_drain();
    chk("cnt_after_partial", bus.elem_cnt_o, 32'd11);

    // nlanes = 0 means all lanes.
    for (int i = 0; i < 4; i++) push_exp(32'h3F800000, i == 3, 1'b0);
    drive_word(32'h3C3C3C3C, 3'd0, 1'b1);
    bus.word_valid_i = 1'b0;
    wait_drain();
    chk("cnt_after_nl0", bus.elem_cnt_o, 32'd15);

    // Back-to-back words with word_valid_i held high.
    xfer_cyc.delete();
    push_exp(32'h3F800000, 1'b0, 1'b0);
    push_exp(32'h37800000, 1'b0, 1'b0);
    push_exp(32'h38400000, 1'b0, 1'b0);
    push_exp(32'h7F800000, 1'b0, 1'b0);
    push_exp(32'h47600000, 1'b0, 1'b0);
    push_exp(32'h80000000, 1'b0, 1'b0);
    push_exp(32'hFF800000, 1'b0, 1'b0);
    push_exp(32'h7FE00000, 1'b1, 1'b1);
    drive_word(32'h7C03013C, 3'd4, 1'b0);
    drive_word(32'h7DFC807B, 3'd4, 1'b1);
    bus.word_valid_i = 1'b0;
    wait_drain();
    chk("b2b_count", xfer_cyc.size(), 32'd8);
    chk("b2b_span", (xfer_cyc.size() == 8) ? xfer_cyc[7] - xfer_cyc[0] : -1, 32'd7);
    chk("cnt_after_b2b", bus.elem_cnt_o, 32'd23);

    // Reset after two lanes discards the rest of the word.
    bus.f32_ready_i = 1'b0;
    push_exp(32'h3F800000, 1'b0, 1'b0);
    push_exp(32'h37800000, 1'b0, 1'b0);
    push_exp(32'h38400000, 1'b0, 1'b0);
    push_exp(32'h7F800000, 1'b1, 1'b0);
    drive_word(32'h7C03013C, 3'd4, 1'b1);
    bus.word_valid_i = 1'b0;
    @(posedge clk);
    #1;
    bus.f32_ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.f32_ready_i = 1'b0;
    chk("pre_rst_remaining", exp_q.size(), 32'd2);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, bus.f32_valid_o}, 32'd0);
    chk("post_rst_cnt", bus.elem_cnt_o, 32'd0);
    chk("post_rst_word_ready", {31'd0, bus.word_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    bus.f32_ready_i = 1'b1;
    push_exp(32'h3F800000, 1'b0, 1'b0);
    push_exp(32'h37800000, 1'b0, 1'b0);
    push_exp(32'h38400000, 1'b0, 1'b0);
    push_exp(32'h7F800000, 1'b1, 1'b0);
    drive_word(32'h7C03013C, 3'd4, 1'b1);
    bus.word_valid_i = 1'b0;
    wait_drain();
    chk("cnt_after_rst_word", bus.elem_cnt_o, 32'd4);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
